eth_tx_frame_arbiter: RTL and testbench

- Shares the single L2 transmit path (CRC append, preamble insert, nibble DDR output) between NUM_SRC frame sources.
- Handshake per source: source raises ReqIn, arbiter pulses ReqConfirm, source streams one frame (Val/SoF/EoF/Data).
- Arbiter muxes the granted stream to one registered byte stream.
- Enforces the inter-frame gap (cycles scaled by MODE), a max-length guard, a grant timeout and LINK_UP gating.

---
 rtl/eth_tx_arb_pkg.sv | 27 ++
 rtl/eth_rr_pick.sv | 42 ++++
 rtl/eth_tx_frame_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// eth_tx_arb_pkg : shared types, constants and helpers for the TX frame arbiter
// Rev 1.0
// ============================================================================
package eth_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_XFER  = 3'd2,
    ST_DROP  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

  localparam int C_BYTE_CNT_W = 11;
  localparam int C_GAP_CNT_W  = 16;

  // 100M nibble mode needs two clock cycles per byte-time.
  function automatic logic [C_GAP_CNT_W-1:0] gap_cycles(input int gap_bytes, input logic mode);
    logic [C_GAP_CNT_W-1:0] v;
    v = C_GAP_CNT_W'(gap_bytes);
    return mode ? v : (v << 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_rr_pick.sv
`default_nettype none
// ============================================================================
// eth_rr_pick : combinational round-robin picker, first requester at/after i_ptr
// Rev 1.0
// ============================================================================
module eth_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_sel;

  // Scan from the farthest offset down so the closest match to the pointer wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
      if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
      end
      w_sel = w_sum[IDX_W-1:0];
      if (i_req[w_sel]) begin
        o_grant = NUM_REQ'(1) << w_sel;
        o_idx   = w_sel;
        o_any   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// eth_tx_frame_arbiter : shares one L2 TX path between NUM_SRC frame sources
// Build option: ETH_ARB_STRICT_PRIO_EN selects fixed priority (index 0 highest)
// Rev 1.0
// ============================================================================
module eth_tx_frame_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_SRC         = 2,
  parameter int GAP_BYTES       = 24,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int GRANT_TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_link_up,
  input  logic                 i_mode,
  input  logic [NUM_SRC-1:0]   i_req_in,
  output logic [NUM_SRC-1:0]   o_req_confirm,
  input  logic [NUM_SRC-1:0]   i_val_in,
  input  logic [NUM_SRC-1:0]   i_sof_in,
  input  logic [NUM_SRC-1:0]   i_eof_in,
  input  logic [8*NUM_SRC-1:0] i_data_in,
  output logic                 o_val_out,
  output logic                 o_sof_out,
  output logic                 o_eof_out,
  output logic [7:0]           o_data_out,
  output logic                 o_busy,
  output logic                 o_err_pulse
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int TMR_W = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [C_BYTE_CNT_W-1:0] C_MAX_BYTES = C_BYTE_CNT_W'(MAX_FRAME_BYTES);

  arb_state_e              r_state, w_state_n;
  logic                    r_link_meta, r_link_sync;
  logic [IDX_W-1:0]        r_gnt_idx, w_gnt_n;
  logic [TMR_W-1:0]        r_tmr, w_tmr_n;
  logic [C_BYTE_CNT_W-1:0] r_cnt, w_cnt_n, w_cnt_inc;
  logic [C_GAP_CNT_W-1:0]  r_gap, w_gap_n;
  logic [NUM_SRC-1:0]      r_req_confirm, w_conf_n;
  logic                    r_val, r_sof, r_eof, r_err;
  logic                    w_val_n, w_sof_n, w_eof_n, w_err_n;
  logic [7:0]              r_data, w_data_n;

  logic [NUM_SRC-1:0]      w_pick_gnt;
  logic [IDX_W-1:0]        w_pick_idx, w_pick_ptr;
  logic                    w_pick_any;
  logic                    w_gap_done;
  logic                    w_g_val, w_g_sof, w_g_eof;
  logic [7:0]              w_g_data;
  logic [7:0]              w_data_arr [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign w_data_arr[gi] = i_data_in[8*gi +: 8];
  end

  assign w_g_val    = i_val_in[r_gnt_idx];
  assign w_g_sof    = i_sof_in[r_gnt_idx];
  assign w_g_eof    = i_eof_in[r_gnt_idx];
  assign w_g_data   = w_data_arr[r_gnt_idx];
  assign w_gap_done = (r_gap <= C_GAP_CNT_W'(1));
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef ETH_ARB_STRICT_PRIO_EN
  assign w_pick_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr, w_ptr_adv;

  assign w_ptr_adv = (r_gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : r_gnt_idx + 1'b1;
  // A grant issued straight out of GAP must already see the advanced pointer.
  assign w_pick_ptr = (r_state == ST_GAP) ? w_ptr_adv : r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (r_state == ST_GAP && w_gap_done) begin
      r_ptr <= w_ptr_adv;
    end
  end
`endif

  eth_rr_pick #(
    .NUM_REQ (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (i_req_in),
    .i_ptr   (w_pick_ptr),
    .o_grant (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt_idx;
    w_tmr_n   = r_tmr;
    w_cnt_n   = r_cnt;
    w_gap_n   = r_gap;
    w_conf_n  = '0;
    w_val_n   = 1'b0;
    w_sof_n   = 1'b0;
    w_eof_n   = 1'b0;
    w_data_n  = '0;
    w_err_n   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_link_sync && w_pick_any) begin
          w_conf_n  = w_pick_gnt;
          w_gnt_n   = w_pick_idx;
          w_tmr_n   = '0;
          w_state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!r_link_sync) begin
          w_gap_n   = gap_cycles(GAP_BYTES, i_mode);
          w_state_n = ST_GAP;
        end else if (w_g_val && w_g_sof) begin
          w_val_n  = 1'b1;
          w_sof_n  = 1'b1;
          w_data_n = w_g_data;
          w_cnt_n  = C_BYTE_CNT_W'(1);
          if (w_g_eof) begin
            w_eof_n   = 1'b1;
            w_gap_n   = gap_cycles(GAP_BYTES, i_mode);
            w_state_n = ST_GAP;
          end else if (MAX_FRAME_BYTES <= 1) begin
            w_eof_n   = 1'b1;
            w_err_n   = 1'b1;
            w_state_n = ST_DROP;
          end else begin
            w_state_n = ST_XFER;
          end
        end else if (r_tmr == TMR_W'(GRANT_TIMEOUT - 1)) begin
          w_err_n   = 1'b1;
          w_gap_n   = gap_cycles(GAP_BYTES, i_mode);
          w_state_n = ST_GAP;
        end else begin
          w_tmr_n = r_tmr + 1'b1;
        end
      end
      ST_XFER: begin
        if (w_g_val) begin
          w_val_n  = 1'b1;
          w_data_n = w_g_data;
          w_cnt_n  = w_cnt_inc;
          if (w_g_eof) begin
            w_eof_n   = 1'b1;
            w_gap_n   = gap_cycles(GAP_BYTES, i_mode);
            w_state_n = ST_GAP;
          end else if (w_cnt_inc == C_MAX_BYTES) begin
            w_eof_n   = 1'b1;
            w_err_n   = 1'b1;
            w_state_n = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (w_g_val && w_g_eof) begin
          w_gap_n   = gap_cycles(GAP_BYTES, i_mode);
          w_state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_gap_done) begin
          if (r_link_sync && w_pick_any) begin
            w_conf_n  = w_pick_gnt;
            w_gnt_n   = w_pick_idx;
            w_tmr_n   = '0;
            w_state_n = ST_GRANT;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else begin
          w_gap_n = r_gap - 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_link_meta   <= 1'b0;
      r_link_sync   <= 1'b0;
      r_state       <= ST_IDLE;
      r_gnt_idx     <= '0;
      r_tmr         <= '0;
      r_cnt         <= '0;
      r_gap         <= '0;
      r_req_confirm <= '0;
      r_val         <= 1'b0;
      r_sof         <= 1'b0;
      r_eof         <= 1'b0;
      r_data        <= '0;
      r_err         <= 1'b0;
    end else begin
      r_link_meta   <= i_link_up;
      r_link_sync   <= r_link_meta;
      r_state       <= w_state_n;
      r_gnt_idx     <= w_gnt_n;
      r_tmr         <= w_tmr_n;
      r_cnt         <= w_cnt_n;
      r_gap         <= w_gap_n;
      r_req_confirm <= w_conf_n;
      r_val         <= w_val_n;
      r_sof         <= w_sof_n;
      r_eof         <= w_eof_n;
      r_data        <= w_data_n;
      r_err         <= w_err_n;
    end
  end

  assign o_req_confirm = r_req_confirm;
  assign o_val_out     = r_val;
  assign o_sof_out     = r_sof;
  assign o_eof_out     = r_eof;
  assign o_data_out    = r_data;
  assign o_err_pulse   = r_err;
  assign o_busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_eth_tx_frame_arbiter : directed self-checking bench for eth_tx_frame_arbiter
// Rev 1.0
// ============================================================================
module tb_eth_tx_frame_arbiter;

  localparam int NUM_SRC         = 2;
  localparam int GAP_BYTES       = 24;
  localparam int MAX_FRAME_BYTES = 1518;
  localparam int GRANT_TIMEOUT   = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_link_up, i_mode;
  logic [NUM_SRC-1:0]   i_req_in, o_req_confirm;
  logic [NUM_SRC-1:0]   i_val_in, i_sof_in, i_eof_in;
  logic [8*NUM_SRC-1:0] i_data_in;
  logic                 o_val_out, o_sof_out, o_eof_out, o_busy, o_err_pulse;
  logic [7:0]           o_data_out;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, err_cnt = 0, conf_cnt = 0, busy_low = 0;
  int last_eof_cyc = 0, conf_cyc = 0;

  always #5 clk = ~clk;

  eth_tx_frame_arbiter #(
    .NUM_SRC         (NUM_SRC),
    .GAP_BYTES       (GAP_BYTES),
    .MAX_FRAME_BYTES (MAX_FRAME_BYTES),
    .GRANT_TIMEOUT   (GRANT_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_link_up     (i_link_up),
    .i_mode        (i_mode),
    .i_req_in      (i_req_in),
    .o_req_confirm (o_req_confirm),
    .i_val_in      (i_val_in),
    .i_sof_in      (i_sof_in),
    .i_eof_in      (i_eof_in),
    .i_data_in     (i_data_in),
    .o_val_out     (o_val_out),
    .o_sof_out     (o_sof_out),
    .o_eof_out     (o_eof_out),
    .o_data_out    (o_data_out),
    .o_busy        (o_busy),
    .o_err_pulse   (o_err_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int s, input int k);
    return 8'(k * 7 + s * 101 + 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (o_err_pulse)     err_cnt++;
    if (|o_req_confirm)  conf_cnt++;
    if (!o_busy)         busy_low++;
  endtask

  task automatic wait_grant(input int src);
    int n = 0;
    while (o_req_confirm == '0 && n < 400) begin
      tick();
      n++;
    end
    chk($sformatf("grant_src%0d", src), 32'(o_req_confirm), 32'(1 << src));
    conf_cyc = cyc;
  endtask

  // Streams one frame; every byte's output is checked one cycle later.
  task automatic send_frame(input int src, input int len, input bit mid_sof, input int link_drop_at);
    logic [10:0] exp, got;
    for (int k = 0; k < len; k++) begin
      i_val_in[src]         = 1'b1;
      i_sof_in[src]         = (k == 0) || (mid_sof && k == len / 2);
      i_eof_in[src]         = (k == len - 1);
      i_data_in[8*src +: 8] = pat(src, k);
      if (k == link_drop_at) i_link_up = 1'b0;
      tick();
      if (k < MAX_FRAME_BYTES)
        exp = {1'b1, k == 0, (k == len - 1) || (k == MAX_FRAME_BYTES - 1), pat(src, k)};
      else
        exp = '0;
      got = {o_val_out, o_sof_out, o_eof_out, o_data_out};
      chk($sformatf("byte_s%0d_k%0d", src, k), 32'(got), 32'(exp));
      if (o_eof_out) last_eof_cyc = cyc;
    end
    i_val_in[src]         = 1'b0;
    i_sof_in[src]         = 1'b0;
    i_eof_in[src]         = 1'b0;
    i_data_in[8*src +: 8] = '0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int e0, c0, t0, n, vleak;
    rst_n = 1'b0; i_link_up = 1'b1; i_mode = 1'b1; i_req_in = '0;
    i_val_in = '0; i_sof_in = '0; i_eof_in = '0; i_data_in = '0;
    repeat (3) tick();
    chk("reset_outs", 32'({o_req_confirm, o_val_out, o_sof_out, o_eof_out, o_data_out, o_busy, o_err_pulse}), 32'd0);
    rst_n = 1'b1;

`ifdef ETH_ARB_STRICT_PRIO_EN
    i_req_in = 2'b11;
    for (int f = 0; f < 3; f++) begin
      wait_grant(0);
      if (f == 2) i_req_in = 2'b10;
      send_frame(0, 8, 1'b0, -1);
    end
    wait_grant(1);
    i_req_in = '0;
    send_frame(1, 8, 1'b0, -1);
    repeat (30) tick();
`else
    // Round robin, 1G: alternating grants, 24-cycle EoFOut->ReqConfirm.
    i_req_in = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_grant(f % 2);
      if (f > 0) chk("ifg_1g", 32'(conf_cyc - last_eof_cyc), 32'd24);
      if (f == 3) i_req_in = '0;
      send_frame(f % 2, 64, 1'b0, -1);
    end
    repeat (30) tick();
`endif

    // 100M: single source back to back, gap doubles, Busy never drops.
    i_mode = 1'b0;
    i_req_in = 2'b01;
    wait_grant(0);
    busy_low = 0;
    send_frame(0, 60, 1'b0, -1);
    wait_grant(0);
    chk("ifg_100m", 32'(conf_cyc - last_eof_cyc), 32'd48);
    chk("busy_held", 32'(busy_low), 32'd0);
    i_req_in = '0;
    send_frame(0, 60, 1'b0, -1);
    repeat (60) tick();
    i_mode = 1'b1;

`ifndef ETH_ARB_STRICT_PRIO_EN
    // Oversized frame from source 1: truncated at MAX_FRAME_BYTES, rest dropped.
    i_req_in = 2'b11;
    wait_grant(1);
    i_req_in = 2'b01;
    e0 = err_cnt;
    send_frame(1, 1600, 1'b0, -1);
    t0 = cyc;
    chk("trunc_err_once", 32'(err_cnt - e0), 32'd1);
    wait_grant(0);
    chk("gap_after_drop", 32'(conf_cyc - t0), 32'd24);
    i_req_in = '0;
    send_frame(0, 4, 1'b1, -1);
    repeat (30) tick();

    // Grant with no SoF: Val alone is ignored, timeout fires 64 cycles on.
    i_req_in = 2'b11;
    wait_grant(1);
    i_req_in = 2'b01;
    e0 = err_cnt;
    i_val_in[1] = 1'b1;
    i_data_in[15:8] = 8'h5A;
    n = 0; vleak = 0;
    while (!o_err_pulse && n < 100) begin
      tick();
      n++;
      if (o_val_out) vleak++;
    end
    t0 = cyc;
    chk("timeout_cycles", 32'(t0 - conf_cyc), 32'd64);
    chk("no_fwd_without_sof", 32'(vleak), 32'd0);
    i_val_in[1] = 1'b0;
    i_data_in[15:8] = '0;
    wait_grant(0);
    chk("gap_after_timeout", 32'(conf_cyc - t0), 32'd24);
    chk("timeout_err_once", 32'(err_cnt - e0), 32'd1);
    // Non-granted source toggles everything while source 0 sends.
    i_req_in = '0;
    i_val_in[1] = 1'b1; i_sof_in[1] = 1'b1; i_eof_in[1] = 1'b1; i_data_in[15:8] = 8'hEE;
    send_frame(0, 5, 1'b0, -1);
    i_val_in[1] = 1'b0; i_sof_in[1] = 1'b0; i_eof_in[1] = 1'b0; i_data_in[15:8] = '0;
    repeat (30) tick();

    // One-byte frame: SoF and EoF together, then a normal gap.
    i_req_in = 2'b10;
    wait_grant(1);
    i_req_in = 2'b01;
    send_frame(1, 1, 1'b0, -1);
    wait_grant(0);
    chk("gap_1byte", 32'(conf_cyc - last_eof_cyc), 32'd24);
    i_req_in = '0;
    send_frame(0, 3, 1'b0, -1);
    repeat (30) tick();
`endif

    // Link drop mid-frame: frame finishes, no grants until link returns.
    i_req_in = 2'b10;
    wait_grant(1);
    i_req_in = '0;
    send_frame(1, 20, 1'b0, 5);
    c0 = conf_cnt;
    i_req_in = 2'b01;
    repeat (60) tick();
    chk("no_grant_link_down", 32'(conf_cnt - c0), 32'd0);
    i_link_up = 1'b1;
    t0 = cyc;
    wait_grant(0);
    // Two synchroniser stages, then the registered ReqConfirm.
    chk("link_resume", 32'(conf_cyc - t0), 32'd3);
    i_req_in = '0;
    send_frame(0, 3, 1'b0, -1);
    repeat (30) tick();

    // Link drop while in GRANT: withdrawn quietly, arbiter back to idle early.
    i_req_in = 2'b10;
    wait_grant(1);
    i_link_up = 1'b0;
    i_req_in = '0;
    e0 = err_cnt;
    repeat (70) tick();
    chk("withdraw_no_err", 32'(err_cnt - e0), 32'd0);
    chk("withdraw_idle", 32'(o_busy), 32'd0);
    i_link_up = 1'b1;
    repeat (3) tick();

    // Reset mid-frame clears outputs without waiting for a clock.
    i_req_in = 2'b01;
    wait_grant(0);
    for (int k = 0; k < 3; k++) begin
      i_val_in[0] = 1'b1; i_sof_in[0] = (k == 0); i_data_in[7:0] = pat(0, k);
      tick();
    end
    chk("mid_frame_active", 32'(o_val_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({o_req_confirm, o_val_out, o_sof_out, o_eof_out, o_data_out, o_busy, o_err_pulse}), 32'd0);
    i_val_in = '0; i_sof_in = '0; i_req_in = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
